stream_demux: RTL

STREAM_DEMUX -- requirements
Module: stream_demux

---
 rtl/stream_demux.sv | 137 +++++++++++++
 1 files changed

// File: rtl/stream_demux.sv
// One-input, two-output stream demultiplexer. Each output has its own 2-deep FIFO
// and a 16-bit count of the beats accepted for it.

module stream_demux_fifo2 #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [width-1:0] data_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [width-1:0] data_o
);
  logic [1:0]       lvl_q, lvl_d;
  logic [width-1:0] head_q, head_d;
  logic [width-1:0] tail_q, tail_d;

  always_comb begin
    lvl_d  = lvl_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (lvl_q == 2'd0) begin
          head_d = data_i;
          lvl_d  = 2'd1;
        end else begin
          tail_d = data_i;
          lvl_d  = 2'd2;
        end
      end
      2'b01: begin
        head_d = tail_q;
        lvl_d  = lvl_q - 2'd1;
      end
      2'b11: begin
        // Level is unchanged; at level 1 the incoming beat replaces the popped head.
        if (lvl_q == 2'd2) begin
          head_d = tail_q;
          tail_d = data_i;
        end else begin
          head_d = data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      lvl_q  <= lvl_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign full_o  = (lvl_q == 2'd2);
  assign valid_o = (lvl_q != 2'd0);
  assign data_o  = valid_o ? head_q : '0;
endmodule

module stream_demux #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] in_data,
  input  logic             in_valid,
  input  logic             s,
  output logic             in_ready,
  output logic [width-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [width-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [15:0]      a_cnt,
  output logic [15:0]      b_cnt
);
  logic        a_full, b_full;
  logic        in_xfer, a_push, b_push, a_pop, b_pop;
  logic [15:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;

  // Ready looks only at the selected FIFO's level, never at downstream ready.
  assign in_ready = !rst && (s ? !a_full : !b_full);
  assign in_xfer  = in_valid && in_ready;
  assign a_push   = in_xfer && s;
  assign b_push   = in_xfer && !s;
  assign a_pop    = a_valid && a_ready;
  assign b_pop    = b_valid && b_ready;

  stream_demux_fifo2 #(.width(width)) u_fifo_a (
    .clk     (clk),
    .rst     (rst),
    .push_i  (a_push),
    .pop_i   (a_pop),
    .data_i  (in_data),
    .full_o  (a_full),
    .valid_o (a_valid),
    .data_o  (a_data)
  );

  stream_demux_fifo2 #(.width(width)) u_fifo_b (
    .clk     (clk),
    .rst     (rst),
    .push_i  (b_push),
    .pop_i   (b_pop),
    .data_i  (in_data),
    .full_o  (b_full),
    .valid_o (b_valid),
    .data_o  (b_data)
  );

  always_comb begin
    a_cnt_d = a_push ? a_cnt_q + 16'd1 : a_cnt_q;
    b_cnt_d = b_push ? b_cnt_q + 16'd1 : b_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign a_cnt = a_cnt_q;
  assign b_cnt = b_cnt_q;
endmodule
